// File: rtl/bcd_display_regs_pkg.sv
// Shared constants and FSM encoding for the BCD display register block.
// Everything here is consumed by the dabble step and the top-level FSM.
package display_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BLANK_CODE = 4'd15;
    localparam int TEMP_MAX = 99;
    localparam int SET_MAX  = 999;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV_T = 2'd1,
        CONV_S = 2'd2,
        PEND   = 2'd3
    } state_t;

endpackage

// File: rtl/bcd_display_regs_dabble_step.sv
// One double-dabble iteration on an N-digit BCD vector: add 3 to every
// nibble >= 5, then shift left one bit taking shift_in as the new LSB.
module bcd_dabble_step
    import display_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N*DIGIT_W-1:0] bcd_i,
    input  logic                 shift_in,
    output logic [N*DIGIT_W-1:0] bcd_o
);

    logic [N*DIGIT_W-1:0] adj;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_adj
            assign adj[gi*DIGIT_W +: DIGIT_W] =
                (bcd_i[gi*DIGIT_W +: DIGIT_W] >= 4'd5) ?
                bcd_i[gi*DIGIT_W +: DIGIT_W] + 4'd3 :
                bcd_i[gi*DIGIT_W +: DIGIT_W];
        end
    endgenerate

    assign bcd_o = (adj << 1) | {{(N*DIGIT_W-1){1'b0}}, shift_in};

endmodule

// File: rtl/bcd_display_regs.sv
// Sequential binary-to-BCD converter for temperature/setpoint digits with a
// shadow stage that only reaches the outputs on a frame-start pulse.
module bcd_display_regs
    import display_pkg::*;
#(
    parameter int                 TEMP_W        = 7,
    parameter int                 SET_W         = 10,
    parameter logic [DIGIT_W-1:0] BLANK_CODE    = display_pkg::BLANK_CODE,
    parameter int                 LEADING_BLANK = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [TEMP_W-1:0]  temp_bin,
    input  logic [SET_W-1:0]   set_bin,
    input  logic               sample,
    input  logic               frame_start,
    output logic [DIGIT_W-1:0] registrotd,
    output logic [DIGIT_W-1:0] registrotu,
    output logic [DIGIT_W-1:0] registrosc,
    output logic [DIGIT_W-1:0] registrosd,
    output logic [DIGIT_W-1:0] registrosu,
    output logic               busy,
    output logic               ovf,
    output logic               sample_drop
);

    localparam int CNT_W = $clog2((TEMP_W > SET_W) ? TEMP_W : SET_W) + 1;
    localparam logic [CNT_W-1:0]  T_LAST = CNT_W'(TEMP_W - 1);
    localparam logic [CNT_W-1:0]  S_LAST = CNT_W'(SET_W - 1);
    localparam logic [TEMP_W-1:0] T_SAT  = TEMP_W'(TEMP_MAX);
    localparam logic [SET_W-1:0]  S_SAT  = SET_W'(SET_MAX);

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [TEMP_W-1:0]          tbin_q, tbin_d;
    logic [SET_W-1:0]           sbin_q, sbin_d;
    logic [2*DIGIT_W-1:0]       tbcd_q, tbcd_d, tbcd_step;
    logic [3*DIGIT_W-1:0]       sbcd_q, sbcd_d, sbcd_step;
    logic                       ovf_pend_q, ovf_pend_d;
    // Digit slots: 4=temp tens, 3=temp units, 2=set hundreds, 1=set tens, 0=set units
    logic [4:0][DIGIT_W-1:0]    shadow_q, shadow_d;
    logic [4:0][DIGIT_W-1:0]    disp_q, disp_d;
    logic                       busy_q, busy_d;
    logic                       ovf_q, ovf_d;
    logic                       drop_q, drop_d;

    bcd_dabble_step #(.N(2)) u_step_t (
        .bcd_i    (tbcd_q),
        .shift_in (tbin_q[TEMP_W-1]),
        .bcd_o    (tbcd_step)
    );

    bcd_dabble_step #(.N(3)) u_step_s (
        .bcd_i    (sbcd_q),
        .shift_in (sbin_q[SET_W-1]),
        .bcd_o    (sbcd_step)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tbin_d     = tbin_q;
        sbin_d     = sbin_q;
        tbcd_d     = tbcd_q;
        sbcd_d     = sbcd_q;
        ovf_pend_d = ovf_pend_q;
        shadow_d   = shadow_q;
        disp_d     = disp_q;
        busy_d     = busy_q;
        ovf_d      = ovf_q;
        drop_d     = sample && (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (sample) begin
                    // Out-of-range values are clamped before conversion so the
                    // dabble naturally produces all nines.
                    tbin_d     = (temp_bin > T_SAT) ? T_SAT : temp_bin;
                    sbin_d     = (set_bin > S_SAT) ? S_SAT : set_bin;
                    ovf_pend_d = (temp_bin > T_SAT) || (set_bin > S_SAT);
                    tbcd_d     = '0;
                    sbcd_d     = '0;
                    cnt_d      = '0;
                    busy_d     = 1'b1;
                    state_d    = CONV_T;
                end
            end
            CONV_T: begin
                tbcd_d = tbcd_step;
                tbin_d = tbin_q << 1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == T_LAST) begin
                    cnt_d       = '0;
                    shadow_d[4] = tbcd_step[2*DIGIT_W-1:DIGIT_W];
                    shadow_d[3] = tbcd_step[DIGIT_W-1:0];
                    state_d     = CONV_S;
                end
            end
            CONV_S: begin
                sbcd_d = sbcd_step;
                sbin_d = sbin_q << 1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == S_LAST) begin
                    cnt_d       = '0;
                    shadow_d[2] = ((LEADING_BLANK != 0) &&
                                   (sbcd_step[3*DIGIT_W-1:2*DIGIT_W] == '0)) ?
                                  BLANK_CODE : sbcd_step[3*DIGIT_W-1:2*DIGIT_W];
                    shadow_d[1] = sbcd_step[2*DIGIT_W-1:DIGIT_W];
                    shadow_d[0] = sbcd_step[DIGIT_W-1:0];
                    state_d     = PEND;
                end
            end
            PEND: begin
                if (frame_start) begin
                    disp_d  = shadow_q;
                    ovf_d   = ovf_pend_q;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            tbin_q     <= '0;
            sbin_q     <= '0;
            tbcd_q     <= '0;
            sbcd_q     <= '0;
            ovf_pend_q <= 1'b0;
            shadow_q   <= {5{BLANK_CODE}};
            disp_q     <= {5{BLANK_CODE}};
            busy_q     <= 1'b0;
            ovf_q      <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tbin_q     <= tbin_d;
            sbin_q     <= sbin_d;
            tbcd_q     <= tbcd_d;
            sbcd_q     <= sbcd_d;
            ovf_pend_q <= ovf_pend_d;
            shadow_q   <= shadow_d;
            disp_q     <= disp_d;
            busy_q     <= busy_d;
            ovf_q      <= ovf_d;
            drop_q     <= drop_d;
        end
    end

    assign registrotd  = disp_q[4];
    assign registrotu  = disp_q[3];
    assign registrosc  = disp_q[2];
    assign registrosd  = disp_q[1];
    assign registrosu  = disp_q[0];
    assign busy        = busy_q;
    assign ovf         = ovf_q;
    assign sample_drop = drop_q;

endmodule

// File: tb/tb_bcd_display_regs.sv
// Bench for bcd_display_regs: table vectors, hand-written corner sequences and
// randomized transactions against an arithmetic digit model.
module tb_bcd_display_regs;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  temp_bin = '0;
    logic [9:0]  set_bin = '0;
    logic        sample = 1'b0;
    logic        frame_start = 1'b0;

    logic [3:0]  a_td, a_tu, a_sc, a_sd, a_su;
    logic [3:0]  b_td, b_tu, b_sc, b_sd, b_su;
    logic        a_busy, a_ovf, a_drop, b_busy, b_ovf, b_drop;
    logic [19:0] dig_a, dig_b;

    assign dig_a = {a_td, a_tu, a_sc, a_sd, a_su};
    assign dig_b = {b_td, b_tu, b_sc, b_sd, b_su};

    always #5 clk = ~clk;

    bcd_display_regs #(.LEADING_BLANK(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .temp_bin(temp_bin), .set_bin(set_bin),
        .sample(sample), .frame_start(frame_start),
        .registrotd(a_td), .registrotu(a_tu), .registrosc(a_sc),
        .registrosd(a_sd), .registrosu(a_su),
        .busy(a_busy), .ovf(a_ovf), .sample_drop(a_drop)
    );

    bcd_display_regs #(.LEADING_BLANK(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .temp_bin(temp_bin), .set_bin(set_bin),
        .sample(sample), .frame_start(frame_start),
        .registrotd(b_td), .registrotu(b_tu), .registrosc(b_sc),
        .registrosd(b_sd), .registrosu(b_su),
        .busy(b_busy), .ovf(b_ovf), .sample_drop(b_drop)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [19:0] exp_a = 20'hFFFFF;
    logic [19:0] exp_b = 20'hFFFFF;
    logic        exp_ovf = 1'b0;

    typedef struct {
        int          t;
        int          s;
        logic [19:0] ea;
        logic [19:0] eb;
        logic        ovf;
    } vec_t;

    vec_t tbl[9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic chk_state(input string name, input logic busy_e, input logic drop_e);
        check({name, "_dig_lb1"}, 32'(dig_a), 32'(exp_a));
        check({name, "_dig_lb0"}, 32'(dig_b), 32'(exp_b));
        check({name, "_busy"}, 32'(a_busy), 32'(busy_e));
        check({name, "_ovf"}, 32'(a_ovf), 32'(exp_ovf));
        check({name, "_drop"}, 32'(a_drop), 32'(drop_e));
        $display("[TB] %s digits=%05h/%05h busy=%0b ovf=%0b drop=%0b",
                 name, dig_a, dig_b, a_busy, a_ovf, a_drop);
    endtask

    // Reference digits from plain decimal arithmetic; 15 marks a blank cell.
    function automatic logic [19:0] model(input int t, input int s, input bit lb);
        int tt, ss, h;
        tt = (t > 99) ? 99 : t;
        ss = (s > 999) ? 999 : s;
        h  = ss / 100;
        if (lb && h == 0) h = 15;
        return {4'(tt / 10), 4'(tt % 10), 4'(h), 4'((ss / 10) % 10), 4'(ss % 10)};
    endfunction

    // Sample in the current cycle k, optional ignored frame_start/sample noise
    // during conversion, commit with frame_start in cycle k+18+extra.
    task automatic run_txn(input string name, input int t, input int s,
                           input logic [19:0] ea, input logic [19:0] eb,
                           input logic ovf_e, input int extra, input bit noise);
        temp_bin = 7'(t);
        set_bin  = 10'(s);
        sample   = 1'b1;
        tick();
        sample   = 1'b0;
        temp_bin = 7'($urandom);
        set_bin  = 10'($urandom);
        check({name, "_busy_start"}, 32'(a_busy), 32'd1);
        for (int j = 1; j <= 17 + extra; j++) begin
            frame_start = noise && (j == 4 || j == 17);
            sample      = noise && (j == 6);
            tick();
            frame_start = 1'b0;
            sample      = 1'b0;
            check({name, "_hold_dig"}, 32'(dig_a), 32'(exp_a));
            check({name, "_hold_busy"}, 32'(a_busy), 32'd1);
            check({name, "_hold_drop"}, 32'(a_drop), 32'(noise && (j == 6)));
        end
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        exp_a   = ea;
        exp_b   = eb;
        exp_ovf = ovf_e;
        chk_state({name, "_commit"}, 1'b0, 1'b0);
    endtask

    initial begin
        tbl[0] = '{37,  205,  20'h37205, 20'h37205, 1'b0};
        tbl[1] = '{5,   42,   20'h05F42, 20'h05042, 1'b0};
        tbl[2] = '{120, 1023, 20'h99999, 20'h99999, 1'b1};
        tbl[3] = '{0,   0,    20'h00F00, 20'h00000, 1'b0};
        tbl[4] = '{99,  999,  20'h99999, 20'h99999, 1'b0};
        tbl[5] = '{100, 1000, 20'h99999, 20'h99999, 1'b1};
        tbl[6] = '{12,  345,  20'h12345, 20'h12345, 1'b0};
        tbl[7] = '{0,   100,  20'h00100, 20'h00100, 1'b0};
        tbl[8] = '{64,  99,   20'h64F99, 20'h64099, 1'b0};

        repeat (3) tick();
        rst_n = 1'b1;

        // Idle with stray frame_start pulses: nothing may change.
        for (int c = 0; c < 100; c++) begin
            frame_start = (c % 17 == 5);
            tick();
            frame_start = 1'b0;
            if (c % 20 == 0) chk_state("idle", 1'b0, 1'b0);
            else check("idle_dig", 32'(dig_a), 32'hFFFFF);
        end

        for (int i = 0; i < 9; i++)
            run_txn($sformatf("vec%0d", i), tbl[i].t, tbl[i].s,
                    tbl[i].ea, tbl[i].eb, tbl[i].ovf, i % 3, 1'b0);

        // Mid-conversion frame_start and dropped sample; original values win.
        temp_bin = 7'd37; set_bin = 10'd205; sample = 1'b1;
        tick();
        sample = 1'b0;
        for (int j = 1; j < 40; j++) begin
            frame_start = (j == 5);
            sample      = (j == 8);
            temp_bin    = (j == 8) ? 7'd11 : 7'd0;
            set_bin     = (j == 8) ? 10'd111 : 10'd0;
            tick();
            frame_start = 1'b0;
            sample      = 1'b0;
            if (j == 5) chk_state("mid_fs_k6", 1'b1, 1'b0);
            if (j == 8) chk_state("mid_drop_k9", 1'b1, 1'b1);
            if (j == 9) chk_state("mid_drop_k10", 1'b1, 1'b0);
        end
        chk_state("mid_k40", 1'b1, 1'b0);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        exp_a = 20'h37205; exp_b = 20'h37205; exp_ovf = 1'b0;
        chk_state("mid_commit_k41", 1'b0, 1'b0);

        // Sample on the commit edge is dropped; the next cycle is accepted.
        temp_bin = 7'd50; set_bin = 10'd600; sample = 1'b1;
        tick();
        sample = 1'b0;
        repeat (17) tick();
        frame_start = 1'b1; sample = 1'b1; temp_bin = 7'd1; set_bin = 10'd1;
        tick();
        frame_start = 1'b0; sample = 1'b0;
        exp_a = 20'h50600; exp_b = 20'h50600;
        chk_state("commit_edge_drop", 1'b0, 1'b1);
        run_txn("after_drop", 10, 20, 20'h10F20, 20'h10020, 1'b0, 0, 1'b0);

        // Asynchronous reset in the middle of CONV_S.
        run_txn("pre_reset", 12, 345, 20'h12345, 20'h12345, 1'b0, 1, 1'b0);
        temp_bin = 7'd77; set_bin = 10'd888; sample = 1'b1;
        tick();
        sample = 1'b0;
        repeat (8) tick();
        rst_n = 1'b0;
        #1;
        exp_a = 20'hFFFFF; exp_b = 20'hFFFFF; exp_ovf = 1'b0;
        chk_state("async_reset", 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        chk_state("reset_release", 1'b0, 1'b0);
        run_txn("post_reset", 77, 888, 20'h77888, 20'h77888, 1'b0, 0, 1'b0);

        // Randomized transactions against the arithmetic model.
        for (int r = 0; r < 40; r++) begin
            int t, s;
            t = (r % 8 == 0) ? int'($urandom_range(100, 127)) : int'($urandom_range(0, 99));
            s = (r % 7 == 0) ? int'($urandom_range(1000, 1023)) : int'($urandom_range(0, 999));
            run_txn($sformatf("rand%0d", r), t, s, model(t, s, 1'b1), model(t, s, 1'b0),
                    (t > 99) || (s > 999), int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
